// File: rtl/pooled_spike_pkg.sv
// Shared constants and types for the pooled delta spike encoder.
package pooled_spike_pkg;

  localparam int GRID_W = 26;
  localparam int GRID_H = 8;
  localparam int N_PIX  = GRID_W * GRID_H;
  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] EOF_ADDR = 8'd255;
  localparam logic [ADDR_W-1:0] LAST_PIX = 8'(N_PIX - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              pol;
  } spike_evt_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event FIFO with two ordered write slots per cycle.
// Slot 0 is written ahead of slot 1; a full FIFO accepts writes when a pop frees room.
module spike_event_fifo
  import pooled_spike_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push0,
  input  spike_evt_t din0,
  input  logic       push1,
  input  spike_evt_t din1,
  input  logic       rd_en,
  output logic       acc0,
  output logic       acc1,
  output spike_evt_t dout,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  spike_evt_t      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count;
  logic [AW+1:0]   room;
  logic [AW-1:0]   wr_idx1;
  logic            pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign pop     = rd_en && !empty;
  // Room counts the entry being popped this same cycle.
  assign room    = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
  assign acc0    = push0 && (room != '0);
  assign acc1    = push1 && (room >= (acc0 ? (AW+2)'(2) : (AW+2)'(1)));
  assign wr_idx1 = wr_ptr[AW-1:0] + AW'(acc0);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr[AW-1:0]] <= din0;
    if (acc1) mem[wr_idx1]        <= din1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(acc0) + (AW+1)'(acc1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pooled_delta_spike_encoder.sv
// Temporal-contrast encoder: compares each pooled pixel with a stored reference and emits ON/OFF events.
// Build option SPIKE_EOF_MARKER_EN appends an end-of-frame marker (addr 255) after every RUN frame.
module pooled_delta_spike_encoder
  import pooled_spike_pkg::*;
#(
  parameter int THRESH     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       frame_start,
  output logic [7:0] spike_addr,
  output logic       spike_pol,
  output logic       spike_valid,
  input  logic       spike_ready,
  output logic       overflow,
  output logic       frame_err,
  output logic       state_dbg
);

  // Handshake: an event transfers on a rising clk edge where spike_valid && spike_ready;
  // while spike_valid && !spike_ready, spike_addr/spike_pol hold their value.

  enc_state_t        state;
  logic [7:0]        pix_cnt;
  logic [7:0]        cur_idx;
  logic [7:0]        ref_mem [N_PIX];
  logic [7:0]        ref_rd;
  logic signed [8:0] diff;
  logic              is_on;
  logic              is_off;

  logic              st_valid;
  logic              st_prime;
  logic              st_evt;
  logic              st_pol;
  logic [7:0]        st_addr;
  logic [7:0]        st_pix;

  logic              ref_we;
  logic              push0;
  logic              acc0;
  logic              acc1;
  logic              fifo_empty;
  spike_evt_t        din0;
  spike_evt_t        din1;
  spike_evt_t        fifo_dout;

  assign cur_idx = frame_start ? 8'd0 : pix_cnt;

  // Forward the pending reference write so a restarted frame never reads a stale entry.
  assign ref_rd = (ref_we && (st_addr == cur_idx)) ? st_pix : ref_mem[cur_idx];
  assign diff   = $signed({1'b0, pix_in}) - $signed({1'b0, ref_rd});
  assign is_on  = (diff >= $signed(9'(THRESH)));
  assign is_off = (diff <= -$signed(9'(THRESH)));

  // Dropped events leave the reference alone so the pixel fires again next frame.
  assign ref_we = st_valid && (st_prime || acc1);

  always_ff @(posedge clk) begin
    if (ref_we) ref_mem[st_addr] <= st_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      pix_cnt   <= '0;
      st_valid  <= 1'b0;
      st_prime  <= 1'b0;
      st_evt    <= 1'b0;
      st_pol    <= 1'b0;
      st_addr   <= '0;
      st_pix    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      st_valid <= pix_valid;
      st_prime <= (state == PRIME);
      st_evt   <= pix_valid && (state == RUN) && (is_on || is_off);
      st_pol   <= is_on;
      st_addr  <= cur_idx;
      st_pix   <= pix_in;

      if (frame_start && (pix_cnt != 8'd0)) frame_err <= 1'b1;

      if (pix_valid) begin
        pix_cnt <= (cur_idx == LAST_PIX) ? 8'd0 : cur_idx + 8'd1;
        if ((state == PRIME) && (cur_idx == LAST_PIX)) state <= RUN;
      end else if (frame_start) begin
        pix_cnt <= 8'd0;
      end

      if ((push0 && !acc0) || (st_evt && !acc1)) overflow <= 1'b1;
    end
  end

`ifdef SPIKE_EOF_MARKER_EN
  logic eof_pend;

  // Marker follows the event slot of the last pixel of a RUN frame by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eof_pend <= 1'b0;
    else        eof_pend <= st_valid && !st_prime && (st_addr == LAST_PIX);
  end

  assign push0 = eof_pend;
  assign din0  = '{addr: EOF_ADDR, pol: 1'b0};
`else
  assign push0 = 1'b0;
  assign din0  = '0;
`endif

  assign din1 = '{addr: st_addr, pol: st_pol};

  spike_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push0 (push0),
    .din0  (din0),
    .push1 (st_evt),
    .din1  (din1),
    .rd_en (spike_ready),
    .acc0  (acc0),
    .acc1  (acc1),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign spike_valid = !fifo_empty;
  assign spike_addr  = fifo_dout.addr;
  assign spike_pol   = fifo_dout.pol;
  assign state_dbg   = state;

endmodule

// File: tb/tb_pooled_delta_spike_encoder.sv
// Scoreboard bench for pooled_delta_spike_encoder: a reference model predicts events as pixels are driven.
`timescale 1ns/1ps
module tb_pooled_delta_spike_encoder;
  import pooled_spike_pkg::*;

  localparam int THRESH = 16;
  localparam int DEPTH  = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] spike_addr;
  logic       spike_pol;
  logic       spike_valid;
  logic       spike_ready;
  logic       overflow;
  logic       frame_err;
  logic       state_dbg;

  pooled_delta_spike_encoder #(
    .THRESH(THRESH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .spike_addr (spike_addr),
    .spike_pol  (spike_pol),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  int         ref_m [N_PIX];
  int         m_cnt;
  bit         m_run;
  int         occ;
  bit         exp_ovf;
  bit         exp_err;
  int         first_valid_cyc;
  int         c37;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pop side: compare the head event on every accepted transfer.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && spike_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (spike_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", {spike_addr, spike_pol}, 9'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("evt", {spike_addr, spike_pol}, e);
          occ--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_push(input logic [8:0] ev, output bit ok);
    ok = (occ < DEPTH);
    if (ok) begin
      exp_q.push_back(ev);
      occ++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic drive_pix(input int v, input bit fs);
    int idx;
    int d;
    bit ok;
    idx = fs ? 0 : m_cnt;
    if (fs && m_cnt != 0) exp_err = 1'b1;
    if (!m_run) begin
      ref_m[idx] = v;
      if (idx == N_PIX - 1) m_run = 1'b1;
    end else begin
      d = v - ref_m[idx];
      if (d >= THRESH || d <= -THRESH) begin
        model_push({8'(idx), (d > 0)}, ok);
        if (ok) ref_m[idx] = v;
      end
`ifdef SPIKE_EOF_MARKER_EN
      if (idx == N_PIX - 1) model_push({EOF_ADDR, 1'b0}, ok);
`endif
    end
    m_cnt       = (idx == N_PIX - 1) ? 0 : idx + 1;
    pix_in      = 8'(v);
    pix_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    if (m_cnt != 0) exp_err = 1'b1;
    m_cnt       = 0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    spike_ready = 1'b1;
    while ((exp_q.size() != 0 || spike_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain_left"}, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_idle_valid"}, spike_valid, 0);
    chk({tag, "_overflow"}, overflow, exp_ovf);
    chk({tag, "_frame_err"}, frame_err, exp_err);
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ     = 0;
    m_cnt   = 0;
    m_run   = 1'b0;
    exp_ovf = 1'b0;
    exp_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pix_in = '0; pix_valid = 1'b0; frame_start = 1'b0; spike_ready = 1'b1;
    first_valid_cyc = -1;
    c37 = 0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_valid", spike_valid, 0);
    chk("rst_addr", spike_addr, 0);
    chk("rst_pol", spike_pol, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_state", state_dbg, PRIME);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Priming frame: no events, state reaches RUN.
    for (int i = 0; i < N_PIX; i++) drive_pix(100, 1'b0);
    drain("t1");
    chk("t1_state_run", state_dbg, RUN);

    // Single bright pixel, latency from drive to valid.
    first_valid_cyc = -1;
    for (int i = 0; i < N_PIX; i++) begin
      if (i == 37) begin
        c37 = cyc;
        drive_pix(120, 1'b0);
      end else begin
        drive_pix(100, 1'b0);
      end
    end
    drain("t2");
    chk("t2_latency", first_valid_cyc - c37, 2);

    // OFF event, sub-threshold, threshold edges, last address.
    for (int i = 0; i < N_PIX; i++) begin
      case (i)
        5:   drive_pix(110, 1'b0);
        10:  drive_pix(116, 1'b0);
        11:  drive_pix(115, 1'b0);
        12:  drive_pix(84, 1'b0);
        13:  drive_pix(85, 1'b0);
        37:  drive_pix(90, 1'b0);
        207: drive_pix(60, 1'b0);
        default: drive_pix(100, 1'b0);
      endcase
    end
    drain("t3");

    // Stalled consumer: FIFO fills, the rest are dropped.
    spike_ready = 1'b0;
    for (int i = 0; i < N_PIX; i++) drive_pix(150, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_held_valid", spike_valid, 1);
    chk("t4_overflow", overflow, exp_ovf);
    chk("t4_queue_len", exp_q.size(), DEPTH);
    chk("t4_head_stable", {spike_addr, spike_pol}, exp_q[0]);
    drain("t4a");
    for (int i = 0; i < N_PIX; i++) drive_pix(150, 1'b0);
    drain("t4b");

    // Early frame_start, then frame_start together with a pixel.
    for (int i = 0; i < 50; i++) drive_pix(150, 1'b0);
    pulse_fs();
    chk("t5_frame_err", frame_err, exp_err);
    drive_pix(200, 1'b0);
    for (int i = 1; i < N_PIX; i++) drive_pix(150, 1'b0);
    for (int i = 0; i < 10; i++) drive_pix(150, 1'b0);
    drive_pix(100, 1'b1);
    for (int i = 1; i < N_PIX; i++) drive_pix(150, 1'b0);
    drain("t5");

    // Random frames.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N_PIX; i++) drive_pix($urandom_range(0, 255), 1'b0);
    drain("t6");

    // Asynchronous reset mid-frame with events queued.
    spike_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_pix(250, 1'b0);
    #3 rst_n = 1'b0;
    #2;
    chk("t7_rst_valid", spike_valid, 0);
    chk("t7_rst_state", state_dbg, PRIME);
    chk("t7_rst_overflow", overflow, 0);
    chk("t7_rst_frame_err", frame_err, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    spike_ready = 1'b1;
    for (int i = 0; i < N_PIX; i++) drive_pix(80, 1'b0);
    chk("t7_state_run", state_dbg, RUN);
    for (int i = 0; i < N_PIX; i++) drive_pix((i == 3) ? 200 : 80, 1'b0);
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
